// File: rtl/monsters_pkg.sv
// Shared types and defaults for the monster formation blocks.
package monsters_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWaitFrame,
      StArbitrate,
      StGrant,
      StCooldown
   } fire_state_t;

   localparam int unsigned MONSTER_AMOUNT_DEFAULT = 16;
   localparam int unsigned MAX_ENEMY_MISSILES     = 4;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request bit strictly after ptr_i, wrapping.
module rr_priority_picker #(
   parameter int unsigned Width    = 16,
   parameter int unsigned IdxWidth = $clog2(Width)
) (
   input  logic [Width-1:0]    req_i,
   input  logic [IdxWidth-1:0] ptr_i,
   output logic                found_o,
   output logic [IdxWidth-1:0] idx_o
);

   localparam logic [IdxWidth:0] WidthExt = (IdxWidth + 1)'(Width);
   localparam logic [IdxWidth:0] OneExt   = (IdxWidth + 1)'(1);

   logic [IdxWidth:0]   start;
   logic [IdxWidth:0]   sum;
   logic [IdxWidth-1:0] offset;
   logic [2*Width-1:0]  dbl;
   logic [Width-1:0]    rot;

   always_comb begin
      start = {1'b0, ptr_i} + OneExt;
      if (start >= WidthExt) start = '0;
      // Doubling the vector turns the wrap-around search into a plain shift.
      dbl     = {req_i, req_i} >> start;
      rot     = dbl[Width-1:0];
      found_o = |rot;
      offset  = '0;
      for (int i = Width - 1; i >= 0; i--) begin
         if (rot[i]) offset = IdxWidth'(i);
      end
      sum = start + {1'b0, offset};
      if (sum >= WidthExt) sum = sum - WidthExt;
      idx_o = sum[IdxWidth-1:0];
   end

endmodule

// File: rtl/monster_fire_arbiter.sv
// Frame-paced round-robin fire scheduler with global cooldown and in-flight missile cap.
module monster_fire_arbiter
   import monsters_pkg::*;
#(
   parameter int unsigned MONSTER_AMOUNT  = MONSTER_AMOUNT_DEFAULT,
   parameter int unsigned IDX_WIDTH       = $clog2(MONSTER_AMOUNT),
   parameter int unsigned GLOBAL_COOLDOWN = 20,
   parameter int unsigned MAX_IN_FLIGHT   = MAX_ENEMY_MISSILES
) (
   input  logic                      clk,
   input  logic                      resetN,
   input  logic                      startOfFrame,
   input  logic                      enable,
   input  logic [MONSTER_AMOUNT-1:0] fire_request,
   input  logic [MONSTER_AMOUNT-1:0] monster_deactivated,
   input  logic                      missile_retired,
   output logic [MONSTER_AMOUNT-1:0] fire_grant,
   output logic                      grant_valid,
   output logic [IDX_WIDTH-1:0]      grant_index,
   output logic [3:0]                in_flight,
   output logic                      cooldown_active
);

   localparam logic [7:0]           CdLoad    = 8'(GLOBAL_COOLDOWN);
   localparam logic [3:0]           FlightCap = 4'(MAX_IN_FLIGHT);
   localparam logic [IDX_WIDTH-1:0] PtrInit   = IDX_WIDTH'(MONSTER_AMOUNT - 1);

   fire_state_t               state_q, state_d;
   logic [IDX_WIDTH-1:0]      last_ptr_q, last_ptr_d;
   logic [IDX_WIDTH-1:0]      sel_q, sel_d;
   logic [7:0]                cd_q, cd_d;
   logic [3:0]                in_flight_q, in_flight_d;
   logic [MONSTER_AMOUNT-1:0] fire_grant_q, fire_grant_d;
   logic                      grant_valid_q, grant_valid_d;
   logic [IDX_WIDTH-1:0]      grant_index_q, grant_index_d;
   logic                      cooldown_active_q, cooldown_active_d;
   logic [MONSTER_AMOUNT-1:0] elig;
   logic                      pick_found;
   logic [IDX_WIDTH-1:0]      pick_idx;
   logic                      granting;

   assign elig = fire_request & ~monster_deactivated;

   rr_priority_picker #(
      .Width    (MONSTER_AMOUNT),
      .IdxWidth (IDX_WIDTH)
   ) u_picker (
      .req_i   (elig),
      .ptr_i   (last_ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      last_ptr_d = last_ptr_q;
      cd_d       = cd_q;
      unique case (state_q)
         StIdle:      state_d = StWaitFrame;
         StWaitFrame: if (startOfFrame) state_d = StArbitrate;
         StArbitrate: begin
            if (pick_found && (in_flight_q < FlightCap)) begin
               sel_d   = pick_idx;
               state_d = StGrant;
            end else begin
               state_d = StWaitFrame;
            end
         end
         StGrant: begin
            last_ptr_d = sel_q;
            cd_d       = CdLoad;
            state_d    = (CdLoad == 8'd0) ? StWaitFrame : StCooldown;
         end
         StCooldown: begin
            if (startOfFrame) begin
               if (cd_q <= 8'd1) begin
                  cd_d    = '0;
                  state_d = StWaitFrame;
               end else begin
                  cd_d = cd_q - 8'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      if (!enable) state_d = StIdle;
   end

   // The grant already left in GRANT, so it is counted even if enable drops that cycle.
   assign granting = (state_q == StGrant);

   always_comb begin
      in_flight_d = in_flight_q;
      if (granting && !missile_retired) begin
         in_flight_d = in_flight_q + 4'd1;
      end else if (!granting && missile_retired && (in_flight_q != 4'd0)) begin
         in_flight_d = in_flight_q - 4'd1;
      end
   end

   // Outputs are registered from the next state so they line up with the GRANT cycle.
   always_comb begin
      grant_valid_d     = (state_d == StGrant);
      fire_grant_d      = grant_valid_d ? (MONSTER_AMOUNT'(1) << sel_d) : '0;
      grant_index_d     = grant_valid_d ? sel_d : grant_index_q;
      cooldown_active_d = (state_d == StCooldown);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q           <= StIdle;
         last_ptr_q        <= PtrInit;
         sel_q             <= '0;
         cd_q              <= '0;
         in_flight_q       <= '0;
         fire_grant_q      <= '0;
         grant_valid_q     <= 1'b0;
         grant_index_q     <= '0;
         cooldown_active_q <= 1'b0;
      end else begin
         state_q           <= state_d;
         last_ptr_q        <= last_ptr_d;
         sel_q             <= sel_d;
         cd_q              <= cd_d;
         in_flight_q       <= in_flight_d;
         fire_grant_q      <= fire_grant_d;
         grant_valid_q     <= grant_valid_d;
         grant_index_q     <= grant_index_d;
         cooldown_active_q <= cooldown_active_d;
      end
   end

   assign fire_grant      = fire_grant_q;
   assign grant_valid     = grant_valid_q;
   assign grant_index     = grant_index_q;
   assign in_flight       = in_flight_q;
   assign cooldown_active = cooldown_active_q;

endmodule

// File: tb/tb_monster_fire_arbiter.sv
// Directed bench: fast instance (no cooldown, cap 15) and slow instance (cooldown 20, cap 4).
module tb_monster_fire_arbiter;

   logic        clk;
   logic        resetN;
   logic        sof;
   logic        retire;
   logic        en_f;
   logic        en_s;
   logic [15:0] req;
   logic [15:0] deact;

   logic [15:0] fg_f, fg_s;
   logic        gv_f, gv_s;
   logic [3:0]  gi_f, gi_s;
   logic [3:0]  if_f, if_s;
   logic        ca_f, ca_s;

   // Values captured at SOF+2 by frame()
   logic        v_f, v_s;
   logic [15:0] g_f, g_s;
   logic [3:0]  i_f, i_s;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] req;
      logic [15:0] deact;
      int          rmode;
      logic        exp_v;
      logic [3:0]  exp_idx;
      logic [3:0]  exp_if;
   } vec_t;

   vec_t tbl[26];

   monster_fire_arbiter #(
      .GLOBAL_COOLDOWN (0),
      .MAX_IN_FLIGHT   (15)
   ) u_fast (
      .clk                 (clk),
      .resetN              (resetN),
      .startOfFrame        (sof),
      .enable              (en_f),
      .fire_request        (req),
      .monster_deactivated (deact),
      .missile_retired     (retire),
      .fire_grant          (fg_f),
      .grant_valid         (gv_f),
      .grant_index         (gi_f),
      .in_flight           (if_f),
      .cooldown_active     (ca_f)
   );

   monster_fire_arbiter #(
      .GLOBAL_COOLDOWN (20),
      .MAX_IN_FLIGHT   (4)
   ) u_slow (
      .clk                 (clk),
      .resetN              (resetN),
      .startOfFrame        (sof),
      .enable              (en_s),
      .fire_request        (req),
      .monster_deactivated (deact),
      .missile_retired     (retire),
      .fire_grant          (fg_s),
      .grant_valid         (gv_s),
      .grant_index         (gi_s),
      .in_flight           (if_s),
      .cooldown_active     (ca_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [15:0] r, input logic [15:0] d, input int rm,
                               input logic v, input logic [3:0] idx, input logic [3:0] fl);
      vec_t t;
      t.req = r; t.deact = d; t.rmode = rm; t.exp_v = v; t.exp_idx = idx; t.exp_if = fl;
      return t;
   endfunction

   // One 5-cycle frame; rmode 1 retires during the GRANT cycle, 2 retires after it.
   task automatic frame(input int rmode);
      sof = 1'b1;
      tick();
      sof = 1'b0;
      check("no_valid_sof1_f", {31'd0, gv_f}, 32'd0);
      check("no_valid_sof1_s", {31'd0, gv_s}, 32'd0);
      tick();
      v_f = gv_f; g_f = fg_f; i_f = gi_f;
      v_s = gv_s; g_s = fg_s; i_s = gi_s;
      if (rmode == 1) retire = 1'b1;
      tick();
      retire = 1'b0;
      check("no_valid_sof3_f", {31'd0, gv_f}, 32'd0);
      check("no_valid_sof3_s", {31'd0, gv_s}, 32'd0);
      if (rmode == 2) retire = 1'b1;
      tick();
      retire = 1'b0;
      tick();
   endtask

   task automatic retire_pulse();
      retire = 1'b1;
      tick();
      retire = 1'b0;
      tick();
   endtask

   task automatic wait_slow_grant(input int limit, output int n);
      n = 0;
      do begin
         frame(0);
         n++;
      end while (!v_s && n < limit);
      check("slow_grant_bound", {31'd0, v_s}, 32'd1);
   endtask

   task automatic skip_cooldown();
      int n;
      n = 0;
      while (ca_s && n < 30) begin
         frame(0);
         n++;
      end
      check("cooldown_end_bound", {31'd0, ca_s}, 32'd0);
   endtask

   initial begin
      int n;
      resetN = 1'b0; sof = 1'b0; retire = 1'b0; en_f = 1'b0; en_s = 1'b0;
      req = '0; deact = '0;
      v_f = 1'b0; v_s = 1'b0; g_f = '0; g_s = '0; i_f = '0; i_s = '0;

      for (int i = 0; i < 17; i++) tbl[i] = mk(16'hFFFF, 16'h0000, 2, 1'b1, 4'(i % 16), 4'd0);
      tbl[17] = mk(16'h0000, 16'h0000, 2, 1'b0, 4'd0,  4'd0);
      tbl[18] = mk(16'h8001, 16'h0001, 2, 1'b1, 4'd15, 4'd0);
      tbl[19] = mk(16'h8001, 16'h0000, 2, 1'b1, 4'd0,  4'd0);
      tbl[20] = mk(16'h0110, 16'h0100, 2, 1'b1, 4'd4,  4'd0);
      tbl[21] = mk(16'h0110, 16'h0000, 2, 1'b1, 4'd8,  4'd0);
      tbl[22] = mk(16'h0110, 16'h0000, 0, 1'b1, 4'd4,  4'd1);
      tbl[23] = mk(16'hFFFF, 16'hFFFF, 0, 1'b0, 4'd4,  4'd1);
      tbl[24] = mk(16'h0004, 16'h0000, 0, 1'b1, 4'd2,  4'd2);
      tbl[25] = mk(16'h0004, 16'h0000, 1, 1'b1, 4'd2,  4'd2);

      repeat (3) tick();
      check("rst_grant", {16'd0, fg_s}, 32'd0);
      check("rst_valid", {31'd0, gv_s}, 32'd0);
      check("rst_index", {28'd0, gi_s}, 32'd0);
      check("rst_in_flight", {28'd0, if_s}, 32'd0);
      check("rst_cooldown", {31'd0, ca_s}, 32'd0);
      resetN = 1'b1;
      tick();

      // Fast instance: table of frames
      en_f = 1'b1;
      tick();
      for (int k = 0; k < 26; k++) begin
         req   = tbl[k].req;
         deact = tbl[k].deact;
         frame(tbl[k].rmode);
         check($sformatf("tbl%0d_valid", k), {31'd0, v_f}, {31'd0, tbl[k].exp_v});
         check($sformatf("tbl%0d_grant", k), {16'd0, g_f},
               tbl[k].exp_v ? (32'd1 << tbl[k].exp_idx) : 32'd0);
         check($sformatf("tbl%0d_index", k), {28'd0, i_f}, {28'd0, tbl[k].exp_idx});
         check($sformatf("tbl%0d_in_flight", k), {28'd0, if_f}, {28'd0, tbl[k].exp_if});
         check($sformatf("tbl%0d_cooldown", k), {31'd0, ca_f}, 32'd0);
      end
      en_f = 1'b0;

      // Slow instance: only index 15 eligible, spacing of 21 frames
      en_s  = 1'b1;
      req   = 16'h8001;
      deact = 16'h0001;
      tick();
      frame(0);
      check("solo_first_valid", {31'd0, v_s}, 32'd1);
      check("solo_first_index", {28'd0, i_s}, 32'd15);
      check("solo_cooldown_active", {31'd0, ca_s}, 32'd1);
      for (int k = 0; k < 2; k++) begin
         wait_slow_grant(30, n);
         check("solo_spacing", n, 32'd21);
         check("solo_index", {28'd0, i_s}, 32'd15);
         check("solo_grant", {16'd0, g_s}, 32'h8000);
      end
      check("solo_in_flight", {28'd0, if_s}, 32'd3);
      repeat (3) retire_pulse();
      check("retired_to_zero", {28'd0, if_s}, 32'd0);

      // Cap of 4 in flight
      req   = 16'hFFFF;
      deact = 16'h0000;
      for (int k = 0; k < 4; k++) begin
         wait_slow_grant(30, n);
         check($sformatf("cap_spacing%0d", k), n, 32'd21);
         check($sformatf("cap_index%0d", k), {28'd0, i_s}, k);
      end
      check("cap_in_flight", {28'd0, if_s}, 32'd4);
      skip_cooldown();
      frame(0);
      check("cap_block1", {31'd0, v_s}, 32'd0);
      frame(0);
      check("cap_block2", {31'd0, v_s}, 32'd0);
      check("cap_hold", {28'd0, if_s}, 32'd4);
      retire_pulse();
      check("cap_after_retire", {28'd0, if_s}, 32'd3);
      frame(0);
      check("cap_regrant_valid", {31'd0, v_s}, 32'd1);
      check("cap_regrant_index", {28'd0, i_s}, 32'd4);
      check("cap_refill", {28'd0, if_s}, 32'd4);

      // Retire coincident with grant at in_flight 2
      retire_pulse();
      retire_pulse();
      check("pre_coincide", {28'd0, if_s}, 32'd2);
      skip_cooldown();
      frame(1);
      check("coincide_valid", {31'd0, v_s}, 32'd1);
      check("coincide_index", {28'd0, i_s}, 32'd5);
      check("coincide_in_flight", {28'd0, if_s}, 32'd2);

      // Enable dropped during cooldown
      check("cd_before_drop", {31'd0, ca_s}, 32'd1);
      en_s = 1'b0;
      tick();
      check("cd_after_drop", {31'd0, ca_s}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         frame(0);
         check("disabled_no_grant", {31'd0, v_s}, 32'd0);
      end
      en_s = 1'b1;
      tick();
      frame(0);
      check("reenable_valid", {31'd0, v_s}, 32'd1);
      check("reenable_index", {28'd0, i_s}, 32'd6);
      check("reenable_in_flight", {28'd0, if_s}, 32'd3);

      // Reset pulsed during a fast GRANT cycle
      en_f = 1'b1;
      tick();
      sof = 1'b1;
      tick();
      sof = 1'b0;
      tick();
      check("pre_reset_valid", {31'd0, gv_f}, 32'd1);
      check("pre_reset_index", {28'd0, gi_f}, 32'd3);
      resetN = 1'b0;
      #1;
      check("async_grant", {16'd0, fg_f}, 32'd0);
      check("async_valid", {31'd0, gv_f}, 32'd0);
      check("async_index", {28'd0, gi_f}, 32'd0);
      check("async_in_flight", {28'd0, if_s}, 32'd0);
      check("async_cooldown", {31'd0, ca_s}, 32'd0);
      #2;
      resetN = 1'b1;
      tick();
      tick();
      frame(0);
      check("post_reset_valid_f", {31'd0, v_f}, 32'd1);
      check("post_reset_index_f", {28'd0, i_f}, 32'd0);
      check("post_reset_grant_f", {16'd0, g_f}, 32'd1);
      check("post_reset_valid_s", {31'd0, v_s}, 32'd1);
      check("post_reset_index_s", {28'd0, i_s}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
